control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 52 +++++
 rtl/cu_moc_timer.sv | 27 ++
 rtl/control_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the control unit: state codes, ALU opcodes, mux selects, control word.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_F1   = 4'd1,
    ST_F2   = 4'd2,
    ST_F3   = 4'd3,
    ST_DEC  = 4'd4,
    ST_DP   = 4'd5,
    ST_LS1  = 4'd6,
    ST_LS2  = 4'd7,
    ST_LS3  = 4'd8,
    ST_BR   = 4'd9
  } cu_state_t;

  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_ADD   = 5'd4;
  localparam logic [4:0] OP_PASSA = 5'd13;

  localparam logic [1:0] MA_RN     = 2'd0;
  localparam logic [1:0] MA_R15    = 2'd2;
  localparam logic [1:0] MB_RM     = 2'd0;
  localparam logic [1:0] MB_IMM    = 2'd1;
  localparam logic [1:0] MB_CONST4 = 2'd2;
  localparam logic [2:0] MC_RD     = 3'd0;
  localparam logic [2:0] MC_R14    = 3'd2;
  localparam logic [2:0] MC_R15    = 3'd3;
  localparam logic [1:0] MF_ALU    = 2'd0;
  localparam logic [1:0] MF_BRANCH = 2'd2;

  localparam int unsigned MOC_TMO_CYCLES = 255;

  typedef struct packed {
    logic [1:0] ma;
    logic [1:0] mb;
    logic [2:0] mc;
    logic       md;
    logic       me;
    logic [1:0] mf;
    logic       mg;
    logic       mh;
    logic [4:0] op;
    logic       rfld;
    logic       irld;
    logic       marld;
    logic       mdrld;
    logic       mfa;
    logic       rw;
  } cu_ctl_t;

endpackage

// File: rtl/cu_moc_timer.sv
// Purpose: counts consecutive cycles spent waiting for moc; only built with CU_MOC_TIMEOUT_EN.
// Latency: expired is a decode of the count register, valid in the 255th wait cycle.
// Backpressure: none; run low (state left or not waiting) clears the count.
module cu_moc_timer
  import cu_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else if (run) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= 8'd0;
    end
  end

  assign expired = (cnt == 8'(MOC_TMO_CYCLES - 1));

endmodule

// File: rtl/control_unit.sv
// Purpose: Moore control FSM sequencing fetch, decode and execute for the datapath.
// Latency: all outputs registered; moc-qualified strobes (ME, MDRLd, err) land the cycle after moc.
// Backpressure: stalls in F3/LS2 until moc; CU_MOC_TIMEOUT_EN bounds the stall at 255 cycles.
module control_unit
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        cond_ok,
  input  logic        moc,
  output logic [1:0]  MA,
  output logic [1:0]  MB,
  output logic [2:0]  MC,
  output logic        MD,
  output logic        ME,
  output logic [1:0]  MF,
  output logic        MG,
  output logic        MH,
  output logic [1:0]  MI,
  output logic [1:0]  MJ,
  output logic [4:0]  op,
  output logic        RFLd,
  output logic        IRLd,
  output logic        MARLd,
  output logic        MDRLd,
  output logic        MFA,
  output logic        RW,
  output logic        err,
  output logic [3:0]  state
);

  cu_state_t state_q, state_nxt;
  logic      link_q, link_nxt;
  cu_ctl_t   ctl_q, ctl_nxt;
  logic      tmo;
  logic      unused_ir;

  // condition and register/offset fields are consumed by the datapath, not here
  assign unused_ir = ^{ir[31:28], ir[22:21], ir[19:0]};

`ifdef CU_MOC_TIMEOUT_EN
  logic in_wait;
  logic err_q;

  assign in_wait = (state_q == ST_F3) || (state_q == ST_LS2);

  cu_moc_timer u_moc_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (in_wait && (state_nxt == state_q)),
    .expired (tmo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= in_wait && !moc && tmo;
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      link_q  <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_nxt;
      link_q  <= link_nxt;
      ctl_q   <= ctl_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    link_nxt  = 1'b0;
    case (state_q)
      ST_IDLE: state_nxt = ST_F1;
      ST_F1:   state_nxt = ST_F2;
      ST_F2:   state_nxt = ST_F3;
      ST_F3: begin
        if (moc)      state_nxt = ST_DEC;
        else if (tmo) state_nxt = ST_F1;
      end
      ST_DEC: begin
        if (!cond_ok)                 state_nxt = ST_F1;
        else if (ir[27:26] == 2'b00)  state_nxt = ST_DP;
        else if (ir[27:26] == 2'b01)  state_nxt = ST_LS1;
        else if (ir[27:25] == 3'b101) begin
          state_nxt = ST_BR;
          link_nxt  = ir[24];
        end else                      state_nxt = ST_F1;
      end
      ST_DP:  state_nxt = ST_F1;
      ST_LS1: state_nxt = ST_LS2;
      ST_LS2: begin
        if (moc)      state_nxt = ir[20] ? ST_LS3 : ST_F1;
        else if (tmo) state_nxt = ST_F1;
      end
      ST_LS3: state_nxt = ST_F1;
      ST_BR:  state_nxt = link_q ? ST_BR : ST_F1;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decoding the next state lets the output register track the state register exactly.
  always_comb begin
    ctl_nxt = '0;
    case (state_nxt)
      ST_F1: begin
        ctl_nxt.marld = 1'b1;
        ctl_nxt.ma    = MA_R15;
        ctl_nxt.md    = 1'b1;
        ctl_nxt.op    = OP_PASSA;
      end
      ST_F2: begin
        ctl_nxt.ma   = MA_R15;
        ctl_nxt.mb   = MB_CONST4;
        ctl_nxt.md   = 1'b1;
        ctl_nxt.op   = OP_ADD;
        ctl_nxt.mc   = MC_R15;
        ctl_nxt.rfld = 1'b1;
        ctl_nxt.mfa  = 1'b1;
        ctl_nxt.rw   = 1'b1;
      end
      ST_F3: begin
        ctl_nxt.mfa = 1'b1;
        ctl_nxt.rw  = 1'b1;
      end
      ST_DEC: ctl_nxt.irld = 1'b1;
      ST_DP: begin
        ctl_nxt.ma   = MA_RN;
        ctl_nxt.mb   = ir[25] ? MB_IMM : MB_RM;
        ctl_nxt.mc   = MC_RD;
        ctl_nxt.mf   = MF_ALU;
        ctl_nxt.rfld = (ir[24:23] != 2'b10);
      end
      ST_LS1: begin
        ctl_nxt.ma    = MA_RN;
        ctl_nxt.mb    = MB_IMM;
        ctl_nxt.md    = 1'b1;
        ctl_nxt.op    = ir[23] ? OP_ADD : OP_SUB;
        ctl_nxt.marld = 1'b1;
      end
      ST_LS2: begin
        ctl_nxt.mfa = 1'b1;
        ctl_nxt.rw  = ir[20];
        ctl_nxt.mh  = ir[20];
      end
      ST_LS3: begin
        ctl_nxt.mg   = 1'b1;
        ctl_nxt.mc   = MC_RD;
        ctl_nxt.rfld = 1'b1;
      end
      ST_BR: begin
        ctl_nxt.ma   = MA_R15;
        ctl_nxt.md   = 1'b1;
        ctl_nxt.rfld = 1'b1;
        if (link_nxt) begin
          ctl_nxt.mc = MC_R14;
          ctl_nxt.op = OP_PASSA;
        end else begin
          ctl_nxt.mc = MC_R15;
          ctl_nxt.mf = MF_BRANCH;
          ctl_nxt.op = OP_ADD;
        end
      end
      default: ctl_nxt = '0;
    endcase
    if ((state_q == ST_LS2) && moc) begin
      ctl_nxt.me    = 1'b1;
      ctl_nxt.mdrld = ir[20];
    end
  end

  assign MA    = ctl_q.ma;
  assign MB    = ctl_q.mb;
  assign MC    = ctl_q.mc;
  assign MD    = ctl_q.md;
  assign ME    = ctl_q.me;
  assign MF    = ctl_q.mf;
  assign MG    = ctl_q.mg;
  assign MH    = ctl_q.mh;
  assign MI    = 2'b00;
  assign MJ    = 2'b00;
  assign op    = ctl_q.op;
  assign RFLd  = ctl_q.rfld;
  assign IRLd  = ctl_q.irld;
  assign MARLd = ctl_q.marld;
  assign MDRLd = ctl_q.mdrld;
  assign MFA   = ctl_q.mfa;
  assign RW    = ctl_q.rw;
  assign state = state_q;

endmodule
